// File: rtl/ahbl_dma_master.sv
// ahbl_dma_master
// ---------------------------------------------------------------------------
// Single-channel memory-to-memory copy engine with an AHB-lite master port.
// Each 32-bit word is moved as one single read followed by one single
// write. Transfers are never pipelined: an address phase is always followed
// by a data phase with HTRANS=IDLE before the next address phase starts.
//
// Handshake: a bus phase (address or data) completes on a rising HCLK edge
// at which HREADY=1. The master keeps every address-phase output stable
// until that edge. HWDATA is stable for the whole write data phase. In a
// data phase, HRESP=1 aborts the copy at the first error cycle, whatever
// the value of HREADY.
//
// Ports:
//   HCLK, HRESET     clock, synchronous active-high reset
//   start            one-cycle copy request, sampled only in IDLE
//   src_addr         source byte address (bits [1:0] treated as 00)
//   dst_addr         destination byte address (bits [1:0] treated as 00)
//   count            number of 32-bit words to copy (0 = empty copy)
//   busy             high while a copy (or its DONE cycle) is in progress
//   done             one-cycle pulse on successful completion
//   err              sticky bus-error flag, cleared by the next accepted start
//   HADDR .. HWDATA  AHB-lite master outputs
//   HRDATA, HREADY,
//   HRESP            AHB-lite master inputs
//   dbg_state        current FSM state (IDLE=0, RD_ADDR=1, RD_DATA=2,
//                    WR_ADDR=3, WR_DATA=4, DONE=5)
// ---------------------------------------------------------------------------
module ahbl_dma_master #(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  output logic [2:0]       dbg_state
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      word_buf;
  logic [CNT_W-1:0] remaining;
  logic             err_q;

  // Last driven address/direction, replayed whenever the FSM is not in an
  // address phase so HADDR/HWRITE never glitch between transfers.
  logic [31:0]      haddr_q;
  logic             hwrite_q;

  logic             accept;
  logic             rd_ok;
  logic             wr_ok;
  logic             bus_err;

  assign accept  = (state == S_IDLE) && start;
  assign rd_ok   = (state == S_RD_DATA) && HREADY && !HRESP;
  assign wr_ok   = (state == S_WR_DATA) && HREADY && !HRESP;
  assign bus_err = ((state == S_RD_DATA) || (state == S_WR_DATA)) && HRESP;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? S_DONE : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (HREADY) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (HRESP)       state_nxt = S_IDLE;
        else if (HREADY) state_nxt = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        if (HREADY) state_nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        if (HRESP) begin
          state_nxt = S_IDLE;
        end else if (HREADY) begin
          state_nxt = (remaining == CNT_W'(1)) ? S_DONE : S_RD_ADDR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      word_buf  <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
    end else begin
      haddr_q  <= HADDR;
      hwrite_q <= HWRITE;

      if (accept) begin
        err_q <= 1'b0;
        if (count != '0) begin
          src_ptr   <= src_addr & 32'hFFFF_FFFC;
          dst_ptr   <= dst_addr & 32'hFFFF_FFFC;
          remaining <= count;
        end
      end

      if (bus_err) begin
        err_q <= 1'b1;
      end

      if (rd_ok) begin
        word_buf <= HRDATA;
      end

      // Pointers wrap naturally at 2^32; single transfers never need a
      // 1 KB boundary split.
      if (wr_ok) begin
        src_ptr   <= src_ptr + 32'd4;
        dst_ptr   <= dst_ptr + 32'd4;
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    HTRANS = TRANS_IDLE;
    HADDR  = haddr_q;
    HWRITE = hwrite_q;
    busy   = 1'b1;
    done   = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_RD_ADDR: begin
        HTRANS = TRANS_NONSEQ;
        HADDR  = src_ptr;
        HWRITE = 1'b0;
      end
      S_WR_ADDR: begin
        HTRANS = TRANS_NONSEQ;
        HADDR  = dst_ptr;
        HWRITE = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        HTRANS = TRANS_IDLE;
      end
    endcase
  end

  assign HSIZE     = 3'b010;
  assign HWDATA    = word_buf;
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ahbl_dma_master.sv
// tb_ahbl_dma_master
// ---------------------------------------------------------------------------
// Bench for ahbl_dma_master. A behavioural AHB-lite slave (word memory held
// in an associative array) answers the master with a programmable number of
// data-phase wait states, an optional error on a chosen read, and an
// optional stall of write address phases. Expected writes, reads and done
// timing come from the copy rules: word i is read from aligned src + 4*i and
// written to aligned dst + 4*i, each word costs 4 + 2*wait cycles, and done
// is seen one cycle after the last word (one cycle after start for count=0).
// ---------------------------------------------------------------------------
module tb_ahbl_dma_master;

  localparam int CNT_W = 16;

  // clock / reset
  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // DUT connections
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [CNT_W-1:0] count = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [31:0]      HWDATA;
  logic [31:0]      HRDATA = '0;
  logic             HREADY = 1'b1;
  logic             HRESP = 1'b0;
  logic [2:0]       dbg_state;

  ahbl_dma_master #(.CNT_W(CNT_W)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q[$];     // expected write data, in order
  logic [31:0] exp_a_q[$];   // expected write addresses
  logic [31:0] exp_r_q[$];   // expected read addresses
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  logic [1:0]  trans_log[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          nonseq_cnt = 0;

  // slave controls
  int          ws = 0;
  int          err_rd_idx = 0;
  int          rd_idx = 0;
  logic        stall_wr_addr = 1'b0;
  logic [31:0] stall_addr_exp = '0;

  // slave data-phase tracking
  logic        dp_active = 1'b0;
  logic        dp_write = 1'b0;
  logic        dp_err = 1'b0;
  int          dp_stage = 0;
  int          dp_wait = 0;
  logic [31:0] dp_addr = '0;
  logic [31:0] dp_wdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // AHB-lite slave + bus monitor. Runs on the falling edge: DUT outputs are
  // settled, and the response it drives is sampled at the next rising edge.
  // -------------------------------------------------------------------------
  always @(negedge HCLK) begin
    if (HRESET) begin
      dp_active = 1'b0;
      dp_stage  = 0;
      HREADY    = 1'b1;
      HRESP     = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) trans_log.push_back(HTRANS);

      if (dp_active) begin
        check("dp_htrans_idle", 32'(HTRANS), 32'd0);
        check("dp_haddr_hold", HADDR, dp_addr);
        if (dp_write) check("dp_hwdata_hold", HWDATA, dp_wdata);
        if (dp_wait > 0) begin
          HREADY = 1'b0;
          HRESP  = 1'b0;
          dp_wait--;
        end else if (dp_stage == 1) begin
          HREADY    = 1'b1;
          HRESP     = 1'b1;
          dp_active = 1'b0;
          dp_stage  = 0;
        end else if (dp_err) begin
          HREADY   = 1'b0;
          HRESP    = 1'b1;
          dp_stage = 1;
        end else begin
          HREADY    = 1'b1;
          HRESP     = 1'b0;
          dp_active = 1'b0;
          if (dp_write) begin
            wr_addr_q.push_back(dp_addr);
            wr_data_q.push_back(HWDATA);
            mem[dp_addr] = HWDATA;
          end else begin
            HRDATA = mem[dp_addr];
          end
        end
      end else begin
        HRESP = 1'b0;
        if (HTRANS == 2'b10 && HWRITE && stall_wr_addr) begin
          HREADY = 1'b0;
          check("stall_haddr_hold", HADDR, stall_addr_exp);
        end else begin
          HREADY = 1'b1;
          if (HTRANS == 2'b10) begin
            nonseq_cnt++;
            dp_active = 1'b1;
            dp_addr   = HADDR;
            dp_write  = HWRITE;
            dp_wdata  = HWDATA;
            dp_wait   = ws;
            dp_stage  = 0;
            dp_err    = 1'b0;
            if (!HWRITE) begin
              rd_addr_q.push_back(HADDR);
              rd_idx++;
              dp_err = (rd_idx == err_rd_idx);
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // driver tasks
  // -------------------------------------------------------------------------
  task automatic prep(input logic [31:0] s, input logic [31:0] d, input int n, input int w);
    logic [31:0] sa;
    logic [31:0] da;
    logic [31:0] a;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    exp_q.delete();
    exp_a_q.delete();
    exp_r_q.delete();
    for (int i = 0; i < n; i++) begin
      a = sa + 32'(4 * i);
      mem[a] = $urandom;
      exp_r_q.push_back(a);
      exp_a_q.push_back(da + 32'(4 * i));
      exp_q.push_back(mem[a]);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    trans_log.delete();
    done_cnt   = 0;
    nonseq_cnt = 0;
    rd_idx     = 0;
    ws         = w;
  endtask

  task automatic start_pulse(input logic [31:0] s, input logic [31:0] d, input int n, output int c0);
    @(posedge HCLK); #2;
    src_addr = s;
    dst_addr = d;
    count    = CNT_W'(n);
    start    = 1'b1;
    c0       = cyc;
    @(posedge HCLK); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    @(posedge HCLK); #3;
    while (busy && i < budget) begin
      @(posedge HCLK); #3;
      i++;
    end
    total++;
    assert (busy === 1'b0) else begin
      bad++;
      $error("FAIL idle_timeout busy=%0b state=%0d expected busy=0", busy, dbg_state);
    end
    repeat (3) @(posedge HCLK);
    #3;
  endtask

  task automatic verify_copy(input int c0, input int n, input int w);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("done_latency", 32'(done_cyc - c0), 32'((n == 0) ? 1 : 1 + n * (4 + 2 * w)));
    check("write_count", 32'(wr_addr_q.size()), 32'(n));
    check("nonseq_count", 32'(nonseq_cnt), 32'(2 * n));
    check("err_clear", 32'(err), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check("write_addr", wr_addr_q[i], exp_a_q[i]);
      check("write_data", wr_data_q[i], exp_q[i]);
    end
    for (int i = 0; i < n && i < rd_addr_q.size(); i++) begin
      check("read_addr", rd_addr_q[i], exp_r_q[i]);
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int w);
    int c0;
    prep(s, d, n, w);
    start_pulse(s, d, n, c0);
    wait_idle(100 + n * 20);
    verify_copy(c0, n, w);
  endtask

  // -------------------------------------------------------------------------
  // directed + random sequence
  // -------------------------------------------------------------------------
  initial begin
    int          c0;
    int          i;
    int          n;
    int          w;
    logic [31:0] s;
    logic [31:0] d;
    logic [1:0]  exp_trans[$];

    // reset values
    repeat (3) @(posedge HCLK);
    #3;
    check("rst_haddr", HADDR, 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_hsize", 32'(HSIZE), 32'd2);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge HCLK); #2;
    HRESET = 1'b0;

    // single word, zero wait states
    prep(32'h2000_0000, 32'h2000_0100, 1, 0);
    mem[32'h2000_0000] = 32'hDEAD_BEEF;
    exp_q[0] = 32'hDEAD_BEEF;
    start_pulse(32'h2000_0000, 32'h2000_0100, 1, c0);
    wait_idle(100);
    verify_copy(c0, 1, 0);
    exp_trans = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    check("trans_len", 32'(trans_log.size()), 32'(exp_trans.size()));
    for (int k = 0; k < exp_trans.size() && k < trans_log.size(); k++) begin
      check("trans_seq", 32'(trans_log[k]), 32'(exp_trans[k]));
    end
    check("hsize_word", 32'(HSIZE), 32'd2);

    // three words, two wait states on every data phase
    run_copy(32'h1000_0040, 32'h1000_4000, 3, 2);

    // zero count
    run_copy(32'h3000_0000, 32'h3000_1000, 0, 0);

    // bus error on the second read data phase
    prep(32'h4000_0000, 32'h4000_2000, 4, 1);
    err_rd_idx = 2;
    start_pulse(32'h4000_0000, 32'h4000_2000, 4, c0);
    wait_idle(200);
    err_rd_idx = 0;
    check("buserr_err", 32'(err), 32'd1);
    check("buserr_busy", 32'(busy), 32'd0);
    check("buserr_done", 32'(done_cnt), 32'd0);
    check("buserr_writes", 32'(wr_addr_q.size()), 32'd1);
    check("buserr_nonseq", 32'(nonseq_cnt), 32'd3);
    if (wr_addr_q.size() > 0) begin
      check("buserr_waddr", wr_addr_q[0], exp_a_q[0]);
      check("buserr_wdata", wr_data_q[0], exp_q[0]);
    end
    repeat (6) @(posedge HCLK);
    #3;
    check("buserr_idle_after", 32'(nonseq_cnt), 32'd3);
    check("buserr_htrans", 32'(HTRANS), 32'd0);
    check("buserr_sticky", 32'(err), 32'd1);

    // start pulsed while busy is ignored (this copy also clears err)
    prep(32'h5000_0010, 32'h5000_3000, 2, 0);
    start_pulse(32'h5000_0010, 32'h5000_3000, 2, c0);
    repeat (2) @(posedge HCLK);
    #2;
    src_addr = 32'h6000_0000;
    dst_addr = 32'h6000_1000;
    count    = CNT_W'(7);
    start    = 1'b1;
    @(posedge HCLK); #2;
    start = 1'b0;
    wait_idle(100);
    verify_copy(c0, 2, 0);

    // reset while a write address phase is stalled
    prep(32'h7000_0000, 32'h7000_0800, 2, 0);
    stall_wr_addr  = 1'b1;
    stall_addr_exp = 32'h7000_0800;
    start_pulse(32'h7000_0000, 32'h7000_0800, 2, c0);
    i = 0;
    while (!(HTRANS == 2'b10 && HWRITE) && i < 50) begin
      @(posedge HCLK); #3;
      i++;
    end
    check("reach_wr_addr", 32'({HTRANS, HWRITE}), 32'h5);
    @(posedge HCLK); #2;
    HRESET = 1'b1;
    @(posedge HCLK); #2;
    HRESET        = 1'b0;
    stall_wr_addr = 1'b0;
    #1;
    check("midrst_htrans", 32'(HTRANS), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_haddr", HADDR, 32'd0);
    check("midrst_hwdata", HWDATA, 32'd0);
    check("midrst_writes", 32'(wr_addr_q.size()), 32'd0);
    run_copy(32'h7000_0000, 32'h7000_0800, 2, 1);

    // pointer wrap past 2^32 with unaligned inputs
    run_copy(32'hFFFF_FFF9, 32'h0000_2002, 4, 0);

    // random copies
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 5);
      w = $urandom_range(0, 2);
      s = $urandom;
      d = s ^ 32'h8000_0000;
      run_copy(s, d, n, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
